mac_accumulator: RTL and testbench

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

---
 rtl/mac_accumulator.sv | 78 +++++++
 tb/tb_mac_accumulator.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// mac_accumulator: signed multiply-accumulate of TAPS operand pairs per result, with a valid/ready handshake on both sides.
// Ports: clk, rst (sync, active-high); start/sel_in begin a job and latch the normalizer select;
// in_valid/in_ready/in_data/in_weight carry operand beats; out_valid/out_ready/out_sum/out_sel carry the result;
// busy is high whenever the block is not idle.
// Build option: define MAC_SAT_EN to clamp the wide accumulator into out_sum instead of wrapping.
module mac_accumulator #(
   parameter int BIT  = 8,
   parameter int TAPS = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            sel_in,
   input  logic                  in_valid,
   input  logic signed [BIT-1:0] in_data,
   input  logic signed [BIT-1:0] in_weight,
   output logic                  in_ready,
   output logic signed [2*BIT-1:0] out_sum,
   output logic [1:0]            out_sel,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy
);
   localparam int AW = 2*BIT + $clog2(TAPS);
   localparam int CW = $clog2(TAPS+1);
   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
   state_t state_q, state_d;
   logic signed [AW-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0] sel_q, sel_d;
   logic signed [2*BIT-1:0] prod;
   assign prod = (2*BIT)'(in_data) * (2*BIT)'(in_weight);
   always_comb begin
      state_d = state_q;
      acc_d = acc_q;
      cnt_d = cnt_q;
      sel_d = sel_q;
      case (state_q)
         IDLE: if (start) begin
            acc_d = '0;
            cnt_d = '0;
            sel_d = sel_in;
            state_d = ACC;
         end
         ACC: if (in_valid) begin
            acc_d = acc_q + AW'(prod);
            cnt_d = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(TAPS-1)) ? DONE : ACC;
         end
         DONE: state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q <= '0;
         cnt_q <= '0;
         sel_q <= '0;
      end else begin
         state_q <= state_d;
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         sel_q <= sel_d;
      end
   end
   assign in_ready = state_q == ACC;
   assign out_valid = state_q == DONE;
   assign busy = state_q != IDLE;
   assign out_sel = sel_q;
`ifdef MAC_SAT_EN
   localparam logic signed [AW-1:0] MAXV = {{(AW-2*BIT+1){1'b0}}, {(2*BIT-1){1'b1}}};
   localparam logic signed [AW-1:0] MINV = {{(AW-2*BIT+1){1'b1}}, {(2*BIT-1){1'b0}}};
   assign out_sum = (acc_q > MAXV) ? MAXV[2*BIT-1:0] : (acc_q < MINV) ? MINV[2*BIT-1:0] : acc_q[2*BIT-1:0];
`else
   assign out_sum = acc_q[2*BIT-1:0];
`endif
endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed jobs against mac_accumulator with a queue-based result scoreboard.
module tb_mac_accumulator;
   logic clk = 0;
   logic rst = 1;
   logic start = 0;
   logic [1:0] sel_in = 0;
   logic in_valid = 0;
   logic signed [7:0] in_data = 0;
   logic signed [7:0] in_weight = 0;
   logic in_ready;
   logic signed [15:0] out_sum;
   logic [1:0] out_sel;
   logic out_valid;
   logic out_ready = 0;
   logic busy;
   int checks = 0;
   int errors = 0;
   typedef struct {int sum; logic [1:0] sel;} exp_t;
   exp_t q[$];
`ifdef MAC_SAT_EN
   localparam int E_POS = 32767;
   localparam int E_NEG = -32768;
`else
   localparam int E_POS = 14089;
   localparam int E_NEG = -15232;
`endif
   mac_accumulator #(.BIT(8), .TAPS(9)) dut (
      .clk(clk), .rst(rst), .start(start), .sel_in(sel_in),
      .in_valid(in_valid), .in_data(in_data), .in_weight(in_weight), .in_ready(in_ready),
      .out_sum(out_sum), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got out_valid=1 expected no pending result");
         end else if (out_ready) begin
            exp_t e;
            e = q.pop_front();
            chk("result_sum", longint'(out_sum), longint'(e.sum));
            chk("result_sel", longint'(out_sel), longint'(e.sel));
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic start_job(input logic [1:0] sel);
      start = 1;
      sel_in = sel;
      tick();
      start = 0;
      chk("busy_after_start", longint'(busy), 1);
      chk("in_ready_in_acc", longint'(in_ready), 1);
   endtask
   task automatic beat(input int d, input int w);
      in_valid = 1;
      in_data = 8'(d);
      in_weight = 8'(w);
      tick();
      in_valid = 0;
   endtask
   task automatic check_reset_outputs(input string tag);
      chk({tag, "_out_sum"}, longint'(out_sum), 0);
      chk({tag, "_out_sel"}, longint'(out_sel), 0);
      chk({tag, "_out_valid"}, longint'(out_valid), 0);
      chk({tag, "_in_ready"}, longint'(in_ready), 0);
      chk({tag, "_busy"}, longint'(busy), 0);
   endtask
   task automatic job(input logic [1:0] sel, input int d[9], input int w[9], input int exp,
                      input bit gaps, input int hold, input bit noise);
      exp_t e;
      out_ready = (hold == 0);
      start_job(sel);
      for (int i = 0; i < 9; i++) begin
         start = noise;
         sel_in = ~sel;
         if (i == 8) begin
            e.sum = exp;
            e.sel = sel;
            q.push_back(e);
            chk("no_early_valid", longint'(out_valid), 0);
         end
         beat(d[i], w[i]);
         if (gaps && i != 8) tick();
      end
      chk("valid_latency", longint'(out_valid), 1);
      chk("in_ready_done", longint'(in_ready), 0);
      chk("sel_latched", longint'(out_sel), longint'(sel));
      for (int k = 0; k < hold; k++) begin
         in_valid = noise;
         in_data = 8'sd100;
         in_weight = 8'sd100;
         chk("hold_valid", longint'(out_valid), 1);
         chk("hold_sum", longint'(out_sum), longint'(exp));
         tick();
      end
      start = 0;
      in_valid = 0;
      out_ready = 1;
      tick();
      chk("valid_one_cycle", longint'(out_valid), 0);
      chk("idle_after_transfer", longint'(busy), 0);
   endtask
   int ones[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
   int p127[9] = '{127, 127, 127, 127, 127, 127, 127, 127, 127};
   int n128[9] = '{-128, -128, -128, -128, -128, -128, -128, -128, -128};
   int mixd[9] = '{3, 5, 0, 0, 0, 0, 0, 0, 0};
   int mixw[9] = '{-2, 4, 0, 0, 0, 0, 0, 0, 0};
   int twos[9] = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
   int threes[9] = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
   initial begin
      tick();
      tick();
      rst = 0;
      check_reset_outputs("reset");
      job(2'b10, ones, ones, 9, 0, 0, 0);
      job(2'b01, p127, p127, E_POS, 0, 0, 0);
      job(2'b11, n128, p127, E_NEG, 0, 0, 0);
      job(2'b01, mixd, mixw, 14, 1, 5, 0);
      start_job(2'b11);
      for (int i = 0; i < 4; i++) beat(2, 3);
      rst = 1;
      tick();
      rst = 0;
      check_reset_outputs("abort");
      job(2'b01, twos, threes, 54, 0, 0, 0);
      in_valid = 1;
      in_data = 8'sd50;
      in_weight = 8'sd50;
      tick();
      tick();
      chk("idle_ignores_in_valid_busy", longint'(busy), 0);
      chk("idle_in_ready", longint'(in_ready), 0);
      in_valid = 0;
      job(2'b10, ones, ones, 9, 0, 3, 1);
      tick();
      chk("queue_drained", longint'(q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
